ws2812_frame_serializer: RTL and testbench

WS2812_FRAME_SERIALIZER -- requirements
Module: ws2812_frame_serializer

---
 rtl/racer_pkg.sv | 34 +++
 rtl/ws2812_bit_timer.sv | 55 +++++
 rtl/ws2812_frame_serializer.sv | 153 +++++++++++++++
 tb/tb_ws2812_frame_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/racer_pkg.sv
// Shared types and default timing for the racer LED strip path.
// Holds the 24-bit GRB colour type, the frame serializer FSM states,
// the default WS2812 timing constants and the optional dimming helper.
package racer_pkg;

  // One LED colour in strip wire order: {G[7:0], R[7:0], B[7:0]}.
  typedef logic [23:0] grb_t;

  // Frame serializer states. The encoding is three bits, and only these
  // five values are ever loaded into the state register.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } state_e;

  // Default timing, counted in system clock cycles.
  localparam int DEF_NUM_LEDS  = 109;
  localparam int DEF_BIT_CLK   = 31;
  localparam int DEF_T0H_CLK   = 10;
  localparam int DEF_T1H_CLK   = 20;
  localparam int DEF_LATCH_CLK = 1250;

  // Bits per LED on the wire.
  localparam int GRB_BITS = 24;

  // Quarter-brightness version of a colour: each 8-bit channel shifted right by 2.
  function automatic grb_t dim_grb(input grb_t c);
    return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// WS2812 single-bit waveform generator.
// While en_i is high, it counts BIT_CLK cycles per bit and drives dout_o high
// for the first T0H_CLK (bit_i=0) or T1H_CLK (bit_i=1) cycles of each period.
// bit_end_o marks the final cycle of a bit period. The counter is held at zero
// while en_i is low, so every enabled stretch begins at the start of a bit.
module ws2812_bit_timer #(
  parameter int BIT_CLK = 31,
  parameter int T0H_CLK = 10,
  parameter int T1H_CLK = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic bit_i,
  output logic dout_o,
  output logic bit_end_o
);

  localparam int CYC_W = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CLK - 1);
  localparam logic [CYC_W-1:0] CYC_T0H  = CYC_W'(T0H_CLK);
  localparam logic [CYC_W-1:0] CYC_T1H  = CYC_W'(T1H_CLK);

  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_d;

  // Bit-period position and high/low decision for the current cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path;
    // defaults come first so that no branch can leave a latch behind.
    cyc_d     = '0;
    bit_end_o = 1'b0;
    dout_o    = 1'b0;
    if (en_i) begin
      bit_end_o = (cyc_q == CYC_LAST);
      dout_o    = (cyc_q < (bit_i ? CYC_T1H : CYC_T0H));
      if (!bit_end_o) begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end
  end

  // Bit-cycle counter register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop in the
    // design samples its inputs at the same edge regardless of block order.
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_serializer.sv
// WS2812 frame serializer for the racer track display.
// On an update_frame pulse it walks LEDs 0..NUM_LEDS-1. For each LED it shows
// the index (FETCH), captures the colour one cycle later (LOAD), shifts its 24
// bits out MSB first (SEND), and after the last LED it holds the line low for
// the latch time (LATCH) and pulses frame_done.
// Optional build macro: LEDS_RACER_DIM_EN -- captured colours are reduced to
// quarter brightness (each channel >> 2). Timing is unchanged.
module ws2812_frame_serializer
  import racer_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int BIT_CLK   = DEF_BIT_CLK,
  parameter int T0H_CLK   = DEF_T0H_CLK,
  parameter int T1H_CLK   = DEF_T1H_CLK,
  parameter int LATCH_CLK = DEF_LATCH_CLK,
  localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update_frame,
  output logic [IDX_W-1:0] led_index,
  input  logic [23:0]      led_grb,
  output logic             dout,
  output logic             busy,
  output logic             frame_done
);

  localparam int LAT_W = (LATCH_CLK > 1) ? $clog2(LATCH_CLK) : 1;

  localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CLK - 1);
  localparam logic [4:0]       BIT_LAST = 5'(GRB_BITS - 1);

  state_e           state_q,   state_d;
  logic [IDX_W-1:0] led_cnt_q, led_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  grb_t             shreg_q,   shreg_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

  grb_t load_grb;
  logic bit_dout;
  logic bit_end;

  // Colour seen by LOAD: either passed through or dimmed to quarter brightness.
`ifdef LEDS_RACER_DIM_EN
  assign load_grb = dim_grb(grb_t'(led_grb));
`else
  assign load_grb = grb_t'(led_grb);
`endif

  // Per-bit waveform: runs only in SEND and sends the current MSB of the shift register.
  ws2812_bit_timer #(
    .BIT_CLK (BIT_CLK),
    .T0H_CLK (T0H_CLK),
    .T1H_CLK (T1H_CLK)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == SEND),
    .bit_i     (shreg_q[GRB_BITS-1]),
    .dout_o    (bit_dout),
    .bit_end_o (bit_end)
  );

  // Next-state logic: frame sequencing, LED and bit counters, shift register, latch timer.
  always_comb begin
    state_d    = state_q;
    led_cnt_d  = led_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    lat_cnt_d  = lat_cnt_q;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // update_frame only matters here, so pulses during a frame are dropped.
        if (update_frame) begin
          state_d   = FETCH;
          led_cnt_d = '0;
        end
      end

      FETCH: begin
        // led_index already shows led_cnt_q. The colour arrives on the next cycle.
        state_d = LOAD;
      end

      LOAD: begin
        shreg_d   = load_grb;
        bit_cnt_d = '0;
        state_d   = SEND;
      end

      SEND: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (led_cnt_q < LAST_LED) begin
              led_cnt_d = led_cnt_q + IDX_W'(1);
              state_d   = FETCH;
            end else begin
              lat_cnt_d = '0;
              state_d   = LATCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shreg_d   = {shreg_q[GRB_BITS-2:0], 1'b0};
          end
        end
      end

      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          frame_done = 1'b1;
          lat_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered FSM state and datapath. Reset overrides any update_frame request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a plain datapath register, not a memory,
      // so clearing it on reset is cheap and keeps post-reset state fully known.
      state_q   <= IDLE;
      led_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      led_cnt_q <= led_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Output decode. dout is forced low outside SEND because the bit timer is disabled there.
  always_comb begin
    led_index = led_cnt_q;
    busy      = (state_q != IDLE);
    dout      = bit_dout;
  end

endmodule

// File: tb/tb_ws2812_frame_serializer.sv
// Self-checking bench for ws2812_frame_serializer (NUM_LEDS=3, BIT_CLK=6,
// T0H_CLK=2, T1H_CLK=4, LATCH_CLK=10). Frame vectors come from a table.
// Each vector lists the LED colours and the GRB words expected on the wire.
// A cycle-accurate reference waveform is built from those words.
// Hand-written sequences cover reset behaviour and a reset during a frame.
module tb_ws2812_frame_serializer;

  localparam int N     = 3;
  localparam int BIT   = 6;
  localparam int T0    = 2;
  localparam int T1    = 4;
  localparam int LAT   = 10;
  localparam int PER   = 146;   // 2 + 24*6 cycles per LED
  localparam int FRAME = 448;   // 3*146 + 10 cycles per frame

  typedef struct packed {
    logic [23:0] c0, c1, c2;    // colours presented for LED 0..2
    logic [23:0] e0, e1, e2;    // words expected on the wire for LED 0..2
    logic [15:0] extra;         // frame cycle of an extra update_frame pulse, FFFF = none
  } vec_t;

  logic        clk;
  logic        rst;
  logic        update_frame;
  logic [1:0]  led_index;
  logic [23:0] led_grb;
  logic        dout;
  logic        busy;
  logic        frame_done;

  logic [23:0] colors [3];
  logic [23:0] exp_w  [3];
  vec_t        vecs   [4];

  int n_cmp = 0;
  int n_bad = 0;

  ws2812_frame_serializer #(
    .NUM_LEDS  (N),
    .BIT_CLK   (BIT),
    .T0H_CLK   (T0),
    .T1H_CLK   (T1),
    .LATCH_CLK (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .update_frame (update_frame),
    .led_index    (led_index),
    .led_grb      (led_grb),
    .dout         (dout),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Colour source with one cycle of latency: after each edge, led_grb shows
  // the colour for the index that was visible during the previous cycle.
  initial begin
    int last_idx;
    last_idx = 0;
    led_grb  = 24'h0;
    forever begin
      @(posedge clk);
      #1;
      led_grb  = (last_idx < N) ? colors[last_idx] : 24'h0;
      last_idx = int'(led_index);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference line level at frame cycle t (t=0 is the first FETCH cycle).
  function automatic logic exp_dout(input int t);
    int   led, r, b, c;
    logic bv;
    led = t / PER;
    r   = t % PER;
    if (led >= N || r < 2) return 1'b0;
    b  = (r - 2) / BIT;
    c  = (r - 2) % BIT;
    bv = exp_w[led][23-b];
    return (c < (bv ? T1 : T0));
  endfunction

  // Starts one frame and checks it cycle by cycle, then checks the cycle after frame_done.
  task automatic run_frame(input vec_t v, input string tag);
    int          hi [3][24];
    int          wave_err, first_err, busy_low, done_cnt, done_at, led, r;
    logic [23:0] dec;
    colors[0] = v.c0; colors[1] = v.c1; colors[2] = v.c2;
    exp_w[0]  = v.e0; exp_w[1]  = v.e1; exp_w[2]  = v.e2;
    for (int l = 0; l < N; l++)
      for (int b = 0; b < 24; b++) hi[l][b] = 0;
    wave_err = 0; first_err = -1; busy_low = 0; done_cnt = 0; done_at = -1;

    @(negedge clk); update_frame = 1'b1;
    @(negedge clk); update_frame = 1'b0;   // now in the first FETCH cycle
    for (int t = 0; t <= FRAME; t++) begin
      if (t < FRAME) begin
        if (dout !== exp_dout(t)) begin
          if (wave_err == 0) first_err = t;
          wave_err++;
        end
        if (busy !== 1'b1) busy_low++;
        if (frame_done === 1'b1) begin
          if (done_cnt == 0) done_at = t;
          done_cnt++;
        end
        led = t / PER;
        r   = t % PER;
        if (led < N && r == 0)
          check($sformatf("%s led_index in FETCH of LED%0d", tag, led), 32'(led_index), 32'(led));
        if (led < N && r >= 2 && dout === 1'b1) hi[led][(r-2)/BIT]++;
      end else begin
        check({tag, " busy after frame_done"}, 32'(busy), 32'd0);
        check({tag, " frame_done after frame"}, 32'(frame_done), 32'd0);
      end
      update_frame = (t == int'(v.extra));
      @(negedge clk);
    end
    update_frame = 1'b0;

    check($sformatf("%s waveform mismatching cycles (first at %0d)", tag, first_err), 32'(wave_err), 32'd0);
    check({tag, " busy low cycles inside frame"}, 32'(busy_low), 32'd0);
    check({tag, " frame_done pulse count"}, 32'(done_cnt), 32'd1);
    check({tag, " frame_done cycle"}, 32'(done_at), 32'(FRAME - 1));
    for (int l = 0; l < N; l++) begin
      for (int b = 0; b < 24; b++) dec[23-b] = (hi[l][b] >= 3);
      check($sformatf("%s decoded word LED%0d", tag, l), 32'(dec), 32'(exp_w[l]));
    end
  endtask

  initial begin
    int done_seen, busy_seen;

    // Hand-computed vectors. The default build sends colours unchanged.
    vecs[0] = '{c0: 24'h800001, c1: 24'h800001, c2: 24'h800001,
                e0: 24'h800001, e1: 24'h800001, e2: 24'h800001, extra: 16'hFFFF};
    vecs[1] = '{c0: 24'hFF0000, c1: 24'h00FF00, c2: 24'h0000FF,
                e0: 24'hFF0000, e1: 24'h00FF00, e2: 24'h0000FF, extra: 16'hFFFF};
    vecs[2] = '{c0: 24'hA5C33C, c1: 24'h000000, c2: 24'hFFFFFF,
                e0: 24'hA5C33C, e1: 24'h000000, e2: 24'hFFFFFF, extra: 16'd100};
    vecs[3] = '{c0: 24'h123456, c1: 24'h789ABC, c2: 24'hDEF012,
                e0: 24'h123456, e1: 24'h789ABC, e2: 24'hDEF012, extra: 16'hFFFF};
    for (int i = 0; i < N; i++) begin
      colors[i] = 24'h0;
      exp_w[i]  = 24'h0;
    end

    // Reset, with update_frame also high during the last reset cycle. That request must be ignored.
    rst = 1'b1;
    update_frame = 1'b0;
    repeat (2) @(negedge clk);
    update_frame = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    update_frame = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle dout c%0d", c), 32'(dout), 32'd0);
      check($sformatf("idle busy c%0d", c), 32'(busy), 32'd0);
      check($sformatf("idle frame_done c%0d", c), 32'(frame_done), 32'd0);
      check($sformatf("idle led_index c%0d", c), 32'(led_index), 32'd0);
    end

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    // Reset at frame cycle 200 (inside LED1): the frame is aborted and frame_done never appears.
    colors[0] = 24'hFFFFFF; colors[1] = 24'hFFFFFF; colors[2] = 24'hFFFFFF;
    @(negedge clk); update_frame = 1'b1;
    @(negedge clk); update_frame = 1'b0;
    done_seen = 0;
    for (int t = 0; t < 200; t++) begin
      if (frame_done === 1'b1) done_seen++;
      @(negedge clk);
    end
    check("mid-frame led_index before reset", 32'(led_index), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort dout", 32'(dout), 32'd0);
    check("abort frame_done", 32'(frame_done), 32'd0);
    check("abort led_index", 32'(led_index), 32'd0);
    busy_seen = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (frame_done === 1'b1) done_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    check("abort frame_done pulses", 32'(done_seen), 32'd0);
    check("abort busy cycles after reset", 32'(busy_seen), 32'd0);

    // A new request after the aborted frame produces a full frame.
    run_frame(vecs[1], "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
